// File: rtl/arb_pkg.sv
// Shared types and helpers for the grant-driven packet mux.
package arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Index width for an N-entry port set; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_oh2idx.sv
// One-hot to binary index encoder with a one-hot validity flag.
module arb_oh2idx
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  oh,
  output logic [IW-1:0] idx,
  output logic          is_onehot
);

  // OR together the indices of set bits; only meaningful when one-hot.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++)
      if (oh[i]) idx = idx | IW'(i);
  end

  assign is_onehot = $onehot(oh);

endmodule

// File: rtl/arb_grant_mux.sv
// Packet-locking mux steered by an upstream one-hot grant, with a
// single full-throughput output register.
module arb_grant_mux
  import arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          grant,
  input  logic [N-1:0]          in_valid,
  input  logic [N-1:0][W-1:0]   in_data,
  input  logic [N-1:0]          in_last,
  output logic [N-1:0]          in_ready,
  output logic                  out_valid,
  output logic [W-1:0]          out_data,
  output logic                  out_last,
  output logic [idx_w(N)-1:0]   out_src,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  grant_err
);

  localparam int IW = idx_w(N);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] lock_q;
  logic [IW-1:0] g_idx;
  logic          g_oh;
  logic          sel_ok;
  logic [IW-1:0] sel_idx;
  logic          can_load;
  logic          go;
  logic          accept;

  arb_oh2idx #(.N(N), .IW(IW)) u_oh2idx (
    .oh        (grant),
    .idx       (g_idx),
    .is_onehot (g_oh)
  );

  // Output register can take a beat when empty or draining this cycle.
  assign can_load = !out_valid || out_ready;

  // Source selection: the lock owner while locked, else a clean grant.
  always_comb begin
    sel_ok  = 1'b0;
    sel_idx = '0;
    if (state_q == LOCKED) begin
      sel_ok  = 1'b1;
      sel_idx = lock_q;
    end else if (g_oh) begin
      sel_ok  = 1'b1;
      sel_idx = g_idx;
    end
  end

  // Ready is a function of state, grant and output space only, never
  // of in_valid, and is forced low while reset is held.
  assign go = !rst && sel_ok && can_load;

  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign in_ready[i] = go && (sel_idx == IW'(i));
  end

  assign accept = go && in_valid[sel_idx];

  // Next state: any accepted beat decides lock by its last flag.
  always_comb begin
    state_d = state_q;
    if (accept) state_d = in_last[sel_idx] ? IDLE : LOCKED;
  end

  // State and lock owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) lock_q <= sel_idx;
    end
  end

  // Output stage: load replaces (or follows) a draining beat, else drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[sel_idx];
      out_last  <= in_last[sel_idx];
      out_src   <= sel_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky flag for a grant with more than one bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   grant_err <= 1'b0;
    else if (|grant && !g_oh)  grant_err <= 1'b1;
  end

  assign busy = (state_q == LOCKED);

endmodule

// File: doc/arb_grant_mux.md
ARB_GRANT_MUX -- requirements
Module: arb_grant_mux

Interface
REQ-001 Parameter N, default 4: number of requester ports, at least 2.
REQ-002 Parameter W, default 32: payload width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 grant  input  N  one-hot grant from the upstream round-robin arbiter; all-zero means no grant.
REQ-006 in_valid  input  N  per-port beat valid.
REQ-007 in_data  input  N x W  per-port payload.
REQ-008 in_last  input  N  per-port last-beat-of-packet flag.
REQ-009 in_ready  output  N  per-port beat accept; at most one bit high.
REQ-010 out_valid  output  1  output beat valid.
REQ-011 out_data  output  W  output payload.
REQ-012 out_last  output  1  output last flag.
REQ-013 out_src  output  clog2(N)  index of the source port for the output beat.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 busy  output  1  high while a packet is locked.
REQ-016 grant_err  output  1  sticky flag; set when grant has more than one bit high.

Function
REQ-017 A beat transfers on a port in a cycle when in_valid and in_ready are both high; an output beat transfers when out_valid and out_ready are both high.
REQ-018 Output register: single stage; it can load when out_valid is low or out_ready is high in the same cycle (full throughput, no bubble).
REQ-019 Latency: an accepted input beat appears on out_* on the next cycle.
REQ-020 FSM has two states, IDLE and LOCKED.
REQ-021 IDLE, selection: when grant is one-hot with set index g, the mux selects port g.
REQ-022 IDLE, transition: if in_valid[g] is high and the output register can load, the beat is accepted.
  - If in_last[g] is 0: go to LOCKED with lock index g.
  - If in_last[g] is 1: stay in IDLE (single-beat packet).
REQ-023 LOCKED: grant is ignored; only the lock port may assert in_ready, gated by the output register's load condition.
REQ-024 LOCKED, exit: return to IDLE on the accepted beat with in_last high.
REQ-025 in_ready must not depend combinationally on in_valid.
REQ-026 Invalid grant in IDLE: if grant is zero or not one-hot, no in_ready is asserted and no beat is accepted.
  - A non-one-hot grant also sets grant_err; grant_err clears only on reset.
REQ-027 Simultaneous load and drain: if the output register holds a beat that is being accepted downstream in the same cycle, the new beat replaces it without loss or duplication.
REQ-028 A port deasserting in_valid mid-packet in LOCKED keeps the lock; no other port is served until that packet's last beat.
REQ-029 busy equals (state == LOCKED).
REQ-030 Payload and out_src are captured only on load; they hold their value while out_valid is high and out_ready is low.

Reset
REQ-031 On rst: state = IDLE, out_valid = 0, busy = 0, grant_err = 0, lock index = 0, out_src = 0, out_last = 0, out_data = 0, in_ready = 0.
REQ-032 Reset asserted mid-packet drops the lock and any held output beat immediately; no partial beat appears after reset is released.
REQ-033 The first acceptance after reset release can occur in the cycle after rst deasserts.

Structure
REQ-034 Shared package arb_pkg contains:
  - the state enum typedef (IDLE, LOCKED);
  - the function computing index width from N.
REQ-035 One sub-module, arb_oh2idx: a parameterised one-hot-to-index encoder that also outputs an is_onehot flag; arb_grant_mux uses it on grant.
REQ-036 No other sub-modules; the output register and FSM are in arb_grant_mux.

Verification
REQ-037 Single-beat packet, N=4: grant=0100, in_valid[2]=1, in_last[2]=1, data 0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_src=2, out_last=1, busy=0.
REQ-038 Three-beat packet on port 1, with grant moving to 0001 after the first beat -> beats 1,2,3 leave in order with out_src=1; in_ready[0] stays 0 until after last; busy high for exactly two cycles.
REQ-039 Backpressure: out_ready=0 for 3 cycles with a beat held -> out_data stable; in_ready all 0; on release, back-to-back beats flow at one per cycle.
REQ-040 grant=0110 -> no in_ready; grant_err=1 next cycle and stays 1 after grant returns to one-hot; cleared only by rst.
REQ-041 rst pulsed mid-packet (lock on port 3, out_valid=1) -> out_valid=0, busy=0 immediately; the next grant to port 0 is served normally.
